program_loader: RTL and testbench

//  Boot-time loader upstream of program_memory: receives a byte stream over a valid/ready link,

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader_word_assembler.sv | 35 +++
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants, state encoding and helpers for the boot-time program loader.
package program_loader_pkg;

  localparam int DEFAULT_INSTR_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH  = 10;

  localparam logic [7:0] LOADER_MAGIC       = 8'hA5;
  localparam int         LOADER_COUNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COUNT_HI = 3'd1,
    ST_COUNT_LO = 3'd2,
    ST_DATA     = 3'd3,
    ST_WRITE    = 3'd4,
    ST_CHECK    = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } loader_state_t;

  // States in which the loader is willing to take a byte off the link.
  function automatic logic state_accepts_byte(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_COUNT_HI) || (s == ST_COUNT_LO) ||
           (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs big-endian bytes into one instruction word; word_full flags the byte that completes it.
module program_loader_word_assembler #(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic [7:0]             byte_in,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_full
);

  localparam int BYTES = INSTR_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [INSTR_WIDTH-1:0] word_reg;
  logic [CNT_W-1:0]       byte_count_reg;
  logic                   last_byte;

  assign last_byte = (byte_count_reg == CNT_W'(BYTES - 1));
  assign word_full = shift_en & last_byte;
  assign word      = word_reg;

  // Earlier bytes move toward the MSBs, so the first byte ends up on top.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_reg       <= '0;
      byte_count_reg <= '0;
    end else if (shift_en) begin
      word_reg       <= INSTR_WIDTH'({word_reg, byte_in});
      byte_count_reg <= last_byte ? '0 : byte_count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: frame parser, program-memory writer and core reset hold.
// Define LOADER_CHECKSUM_EN to require a trailing XOR check byte before release.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          INSTR_WIDTH  = DEFAULT_INSTR_WIDTH,
  parameter int          ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned BASE_ADDRESS = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   pm_write_enable,
  output logic [ADDR_WIDTH-1:0]  pm_address,
  output logic [INSTR_WIDTH-1:0] pm_data,
  output logic                   core_reset_n,
  output logic                   load_done,
  output logic                   load_error
);

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE_ADDRESS);

  loader_state_t                 state_reg;
  logic [7:0]                    count_hi_reg;
  logic [LOADER_COUNT_WIDTH-1:0] words_remaining_reg;
  logic [LOADER_COUNT_WIDTH-1:0] word_count;
  logic [ADDR_WIDTH-1:0]         pm_address_reg;
  logic                          core_reset_n_reg;
  logic                          load_done_reg;
  logic                          byte_accept;
  logic                          shift_en;
  logic                          word_full;

  assign rx_ready        = state_accepts_byte(state_reg);
  assign pm_write_enable = (state_reg == ST_WRITE);
  assign byte_accept     = rx_valid & rx_ready;
  assign shift_en        = byte_accept & (state_reg == ST_DATA);
  assign word_count      = {count_hi_reg, rx_data};
  assign pm_address      = pm_address_reg;
  assign core_reset_n    = core_reset_n_reg;
  assign load_done       = load_done_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_reg;
  logic       load_error_reg;
  assign load_error = load_error_reg;
`else
  assign load_error = 1'b0;
`endif

  program_loader_word_assembler #(
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_word_assembler (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shift_en),
    .byte_in  (rx_data),
    .word     (pm_data),
    .word_full(word_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg           <= ST_IDLE;
      count_hi_reg        <= '0;
      words_remaining_reg <= '0;
      pm_address_reg      <= BASE_ADDR;
      core_reset_n_reg    <= 1'b0;
      load_done_reg       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_reg        <= '0;
      load_error_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (byte_accept && (rx_data == LOADER_MAGIC)) state_reg <= ST_COUNT_HI;
        end
        ST_COUNT_HI: begin
          if (byte_accept) begin
            count_hi_reg <= rx_data;
            state_reg    <= ST_COUNT_LO;
          end
        end
        ST_COUNT_LO: begin
          if (byte_accept) begin
            words_remaining_reg <= word_count;
            if (word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_reg        <= ST_CHECK;
`else
              state_reg        <= ST_DONE;
              load_done_reg    <= 1'b1;
              core_reset_n_reg <= 1'b1;
`endif
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (byte_accept) begin
`ifdef LOADER_CHECKSUM_EN
            checksum_reg <= checksum_reg ^ rx_data;
`endif
            if (word_full) state_reg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Address wraps modulo 2^ADDR_WIDTH by construction of the register width.
          pm_address_reg      <= pm_address_reg + 1'b1;
          words_remaining_reg <= words_remaining_reg - 1'b1;
          if (words_remaining_reg == LOADER_COUNT_WIDTH'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_reg        <= ST_CHECK;
`else
            state_reg        <= ST_DONE;
            load_done_reg    <= 1'b1;
            core_reset_n_reg <= 1'b1;
`endif
          end else begin
            state_reg <= ST_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (byte_accept) begin
            if (rx_data == checksum_reg) begin
              state_reg        <= ST_DONE;
              load_done_reg    <= 1'b1;
              core_reset_n_reg <= 1'b1;
            end else begin
              state_reg      <= ST_ERROR;
              load_error_reg <= 1'b1;
            end
          end
        end
`else
        ST_CHECK: state_reg <= ST_IDLE;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level model plus literal spot checks.
// Honours LOADER_CHECKSUM_EN the same way the design does.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic        rx_ready0, pm_we0, core_reset_n0, load_done0, load_error0;
  logic [9:0]  pm_address0;
  logic [31:0] pm_data0;
  logic        rx_ready1, pm_we1, core_reset_n1, load_done1, load_error1;
  logic [3:0]  pm_address1;
  logic [31:0] pm_data1;

  always #5 clock = ~clock;

  program_loader #(.INSTR_WIDTH(32), .ADDR_WIDTH(10), .BASE_ADDRESS(0)) dut0 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready0), .pm_write_enable(pm_we0), .pm_address(pm_address0),
    .pm_data(pm_data0), .core_reset_n(core_reset_n0), .load_done(load_done0),
    .load_error(load_error0)
  );

  program_loader #(.INSTR_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDRESS(14)) dut1 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready1), .pm_write_enable(pm_we1), .pm_address(pm_address1),
    .pm_data(pm_data1), .core_reset_n(core_reset_n1), .load_done(load_done1),
    .load_error(load_error1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model of the accepted byte stream ----------------
  bit          m_synced, m_wp, m_await, m_done, m_error, m_acc;
  bit          m_ready = 1'b1;
  int          m_hdr, m_n, m_data_bytes, m_idx, m_written;
  logic [31:0] m_word;
  logic [7:0]  m_sum;

  task automatic model_clear();
    m_synced = 0; m_wp = 0; m_await = 0; m_done = 0; m_error = 0; m_ready = 1;
    m_hdr = 0; m_n = 0; m_data_bytes = 0; m_idx = 0; m_written = 0;
    m_word = '0; m_sum = '0;
  endtask

  task automatic model_finish();
`ifdef LOADER_CHECKSUM_EN
    m_await = 1;
`else
    m_done = 1;
`endif
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_clear();
    end else begin
      m_acc = rx_valid && m_ready;
      if (m_wp) begin
        m_wp = 0;
        m_written++;
        if (m_written == m_n) model_finish();
      end
      if (m_acc) begin
        if (!m_synced) begin
          m_synced = (rx_data == 8'hA5);
        end else if (m_hdr < 2) begin
          m_n = (m_n << 8) | int'(rx_data);
          m_hdr++;
          if (m_hdr == 2 && m_n == 0) model_finish();
        end else if (m_data_bytes < m_n * 4) begin
          m_word = {m_word[23:0], rx_data};
          m_sum  = m_sum ^ rx_data;
          m_data_bytes++;
          if (m_data_bytes % 4 == 0) begin
            m_idx = m_data_bytes / 4 - 1;
            m_wp  = 1;
          end
        end else if (m_await) begin
          m_await = 0;
          if (rx_data == m_sum) m_done = 1;
          else m_error = 1;
        end
      end
      m_ready = !m_wp && !m_done && !m_error;
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clock) begin
    chk("rx_ready", rx_ready0, m_ready);
    chk("pm_write_enable", pm_we0, m_wp);
    chk("load_done", load_done0, m_done);
    chk("core_reset_n", core_reset_n0, m_done);
    chk("load_error", load_error0, m_error);
    chk("rx_ready_b14", rx_ready1, m_ready);
    chk("pm_write_enable_b14", pm_we1, m_wp);
    if (m_wp) begin
      chk("pm_address", pm_address0, 64'((m_idx) % 1024));
      chk("pm_data", pm_data0, m_word);
      chk("pm_address_b14", pm_address1, 64'((14 + m_idx) % 16));
      chk("pm_data_b14", pm_data1, m_word);
    end
  end

  // ---------------- write log for literal checks ----------------
  logic [9:0]  log0_addr[$];
  logic [31:0] log0_data[$];
  logic [3:0]  log1_addr[$];
  int          strobe_cyc = -1;
  int          done_cyc = -1;

  always @(negedge clock) begin
    if (pm_we0) begin
      log0_addr.push_back(pm_address0);
      log0_data.push_back(pm_data0);
      strobe_cyc = cyc;
      $display("write: addr=%0d data=%08h (base14 addr=%0d)", pm_address0, pm_data0, pm_address1);
    end
    if (pm_we1) log1_addr.push_back(pm_address1);
    if (load_done0 && done_cyc < 0) done_cyc = cyc;
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    rx_valid = 1'b0;
    @(negedge clock);
    chk("rst rx_ready", rx_ready0, 1);
    chk("rst pm_write_enable", pm_we0, 0);
    chk("rst core_reset_n", core_reset_n0, 0);
    chk("rst load_done", load_done0, 0);
    chk("rst pm_address", pm_address0, 0);
    chk("rst pm_address_b14", pm_address1, 14);
    chk("rst pm_data", pm_data0, 0);
    log0_addr.delete(); log0_data.delete(); log1_addr.delete();
    strobe_cyc = -1; done_cyc = -1;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clock); #1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rx_ready0) begin
        @(posedge clock); #1;
        ok = 1;
        break;
      end
    end
    rx_valid = 1'b0;
    chk("byte accepted", ok, 1);
    $display("byte %02h sent", b);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  logic [7:0] sum3;

  initial begin
    do_reset();

    // 1: reset in the middle of DATA
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0);
    chk("t1 no write before reset", log0_addr.size(), 0);
    do_reset();

    // 2: junk, then a one-word frame
    send_byte(8'h00, 0); send_byte(8'h17, 0); send_byte(8'hA5, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h22, 0);
`endif
    idle(3);
    chk("t2 write count", log0_addr.size(), 1);
    if (log0_addr.size() > 0) begin
      chk("t2 addr", log0_addr[0], 0);
      chk("t2 data", log0_data[0], 32'hDEADBEEF);
    end
    chk("t2 load_done", load_done0, 1);
    chk("t2 core_reset_n", core_reset_n0, 1);
`ifndef LOADER_CHECKSUM_EN
    chk("t2 done one cycle after strobe", done_cyc - strobe_cyc, 1);
`endif

    // 3 and 6: three words with rx_valid gaps; base-14 copy wraps
    do_reset();
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
    sum3 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      send_byte(8'h10 + 8'(i), 1);
      sum3 = sum3 ^ (8'h10 + 8'(i));
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum3, 1);
`endif
    idle(3);
    chk("t3 write count", log0_addr.size(), 3);
    if (log0_addr.size() == 3) begin
      chk("t3 addr0", log0_addr[0], 0);
      chk("t3 addr1", log0_addr[1], 1);
      chk("t3 addr2", log0_addr[2], 2);
      chk("t3 data0", log0_data[0], 32'h10111213);
      chk("t3 data1", log0_data[1], 32'h14151617);
      chk("t3 data2", log0_data[2], 32'h18191A1B);
    end
    chk("t6 write count", log1_addr.size(), 3);
    if (log1_addr.size() == 3) begin
      chk("t6 addr0", log1_addr[0], 14);
      chk("t6 addr1", log1_addr[1], 15);
      chk("t6 addr2", log1_addr[2], 0);
    end
    chk("t3 load_done", load_done0, 1);

    // 4: empty image, later bytes ignored
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    idle(2);
    chk("t4 load_done", load_done0, 1);
    rx_data = 8'h5A;
    rx_valid = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    rx_valid = 1'b0;
    @(negedge clock);
    chk("t4 rx_ready", rx_ready0, 0);
    chk("t4 no writes", log0_addr.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    // 5: checksum match and mismatch
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h44, 0);
    idle(2);
    chk("t5 good load_done", load_done0, 1);
    chk("t5 good load_error", load_error0, 0);
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h45, 0);
    idle(2);
    chk("t5 bad load_error", load_error0, 1);
    chk("t5 bad core_reset_n", core_reset_n0, 0);
    chk("t5 bad load_done", load_done0, 0);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
